// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame scheduler: default sync byte,
// transmit FSM states and the packet length calculation.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } state_e;

  // Sync + sequence + payload + checksum.
  function automatic int packet_len(input int slots, input int bytes_per_sample);
    return 3 + slots * bytes_per_sample;
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Trigger/busy handshake between the frame scheduler (master) and the
// byte-wide UART transmitter (slave).
interface uart_frame_scheduler_if;
  logic [7:0] byte_out;
  logic       byte_valid_out;
  logic       busy_in;

  modport master (
    output byte_out,
    output byte_valid_out,
    input  busy_in
  );

  modport slave (
    input  byte_out,
    input  byte_valid_out,
    output busy_in
  );
endinterface

// File: rtl/frame_byte_mux.sv
// Combinational selection of one packet byte from the latched frame, the
// packet index, the sequence number and the running checksum.
module frame_byte_mux
  import uart_frame_pkg::*;
#(
  parameter int         SLOTS            = 2,
  parameter int         SAMPLE_WIDTH     = 24,
  parameter int         BYTES_PER_SAMPLE = 2,
  parameter logic [7:0] SYNC_BYTE        = SYNC_BYTE_DEFAULT,
  parameter int         IDX_W            = 3
) (
  input  logic [SLOTS-1:0][SAMPLE_WIDTH-1:0] samples_in,
  input  logic [IDX_W-1:0]                   idx_in,
  input  logic [7:0]                         seq_in,
  input  logic [7:0]                         csum_in,
  output logic [7:0]                         byte_out
);

  localparam int PAYLOAD_N = SLOTS * BYTES_PER_SAMPLE;
  localparam int PKT_LEN   = packet_len(SLOTS, BYTES_PER_SAMPLE);

  logic [7:0] payload [PAYLOAD_N];
  // Low-order sample bits beyond BYTES_PER_SAMPLE are never transmitted.
  logic       unused_sample_bits;

  assign unused_sample_bits = ^samples_in;

  genvar gi;
  generate
    for (gi = 0; gi < PAYLOAD_N; gi++) begin : g_payload
      assign payload[gi] =
        samples_in[gi / BYTES_PER_SAMPLE][SAMPLE_WIDTH-1-8*(gi % BYTES_PER_SAMPLE) -: 8];
    end
  endgenerate

  always_comb begin
    byte_out = SYNC_BYTE;
    if (idx_in == IDX_W'(1)) begin
      byte_out = seq_in;
    end else if (idx_in == IDX_W'(PKT_LEN - 1)) begin
      byte_out = csum_in;
    end else begin
      for (int p = 0; p < PAYLOAD_N; p++) begin
        if (idx_in == IDX_W'(p + 2)) begin
          byte_out = payload[p];
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Captures all TDM slot samples on each new frame and serialises them as a
// sync/seq/payload/checksum packet through the shared UART transmitter.
module uart_frame_scheduler
  import uart_frame_pkg::*;
#(
  parameter int         SLOTS            = 2,
  parameter int         SAMPLE_WIDTH     = 24,
  parameter int         BYTES_PER_SAMPLE = 2,
  parameter logic [7:0] SYNC_BYTE        = SYNC_BYTE_DEFAULT
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              en_in,
  input  logic [SLOTS-1:0][SAMPLE_WIDTH-1:0] audio_in,
  input  logic                              audio_valid_in,
  uart_frame_scheduler_if.master            tx_if,
  output logic                              frame_active_out,
  output logic [7:0]                        seq_out,
  output logic [15:0]                       overrun_count_out
);

  localparam int PKT_LEN = packet_len(SLOTS, BYTES_PER_SAMPLE);
  localparam int IDX_W   = $clog2(PKT_LEN);

  typedef logic [SLOTS-1:0][SAMPLE_WIDTH-1:0] frame_t;

  state_e           state_q,    state_d;
  logic             pending_q,  pending_d;
  frame_t           pend_buf_q, pend_buf_d;
  frame_t           tx_buf_q,   tx_buf_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [7:0]       seq_q,      seq_d;
  logic [15:0]      ovr_q,      ovr_d;
  logic [7:0]       byte_q,     byte_d;
  logic             valid_q,    valid_d;
  logic             active_q,   active_d;
  logic [7:0]       csum_q,     csum_d;
  logic             av_prev_q,  av_prev_d;

  logic       capture;
  logic       consume;
  logic [7:0] mux_byte;

  frame_byte_mux #(
    .SLOTS            (SLOTS),
    .SAMPLE_WIDTH     (SAMPLE_WIDTH),
    .BYTES_PER_SAMPLE (BYTES_PER_SAMPLE),
    .SYNC_BYTE        (SYNC_BYTE),
    .IDX_W            (IDX_W)
  ) u_mux (
    .samples_in (tx_buf_q),
    .idx_in     (idx_q),
    .seq_in     (seq_q),
    .csum_in    (csum_q),
    .byte_out   (mux_byte)
  );

  assign capture = audio_valid_in && !av_prev_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    pend_buf_d = pend_buf_q;
    tx_buf_d   = tx_buf_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    ovr_d      = ovr_q;
    byte_d     = byte_q;
    valid_d    = 1'b0;
    active_d   = active_q;
    csum_d     = csum_q;
    av_prev_d  = audio_valid_in;
    consume    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q && en_in && !tx_if.busy_in) begin
          consume   = 1'b1;
          tx_buf_d  = pend_buf_q;
          pending_d = 1'b0;
          idx_d     = '0;
          active_d  = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        byte_d  = mux_byte;
        valid_d = 1'b1;
        // Checksum covers bytes 1..L-2, so the sync byte restarts it.
        csum_d  = (idx_q == '0) ? 8'h00 : (csum_q ^ mux_byte);
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_if.busy_in) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_if.busy_in) begin
          if (idx_q == IDX_W'(PKT_LEN - 1)) begin
            seq_d    = seq_q + 8'd1;
            active_d = 1'b0;
            state_d  = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A capture coinciding with IDLE taking the old frame is not a drop.
    if (capture) begin
      pend_buf_d = audio_in;
      pending_d  = 1'b1;
      if (pending_q && !consume && (ovr_q != 16'hFFFF)) begin
        ovr_d = ovr_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      pend_buf_q <= '0;
      tx_buf_q   <= '0;
      idx_q      <= '0;
      seq_q      <= '0;
      ovr_q      <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      csum_q     <= '0;
      av_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pend_buf_q <= pend_buf_d;
      tx_buf_q   <= tx_buf_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      ovr_q      <= ovr_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      csum_q     <= csum_d;
      av_prev_q  <= av_prev_d;
    end
  end

  assign tx_if.byte_out       = byte_q;
  assign tx_if.byte_valid_out = valid_q;
  assign frame_active_out     = active_q;
  assign seq_out              = seq_q;
  assign overrun_count_out    = ovr_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Scoreboard bench: expected packet bytes are queued when a frame is driven
// and compared as the transmitter model receives each triggered byte.
module tb_uart_frame_scheduler;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             en_in;
  logic [1:0][23:0] audio_in;
  logic             audio_valid_in;
  logic             frame_active_out;
  logic [7:0]       seq_out;
  logic [15:0]      overrun_count_out;

  uart_frame_scheduler_if tx_if ();

  uart_frame_scheduler #(
    .SLOTS            (2),
    .SAMPLE_WIDTH     (24),
    .BYTES_PER_SAMPLE (2),
    .SYNC_BYTE        (8'hA5)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .en_in             (en_in),
    .audio_in          (audio_in),
    .audio_valid_in    (audio_valid_in),
    .tx_if             (tx_if),
    .frame_active_out  (frame_active_out),
    .seq_out           (seq_out),
    .overrun_count_out (overrun_count_out)
  );

  always #5 clk_in = ~clk_in;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  int         hi_delay = 0;
  int         busy_len = 3;
  logic       model_busy;
  logic       model_armed;
  int         dly_cnt;
  int         hold_cnt;
  int         trig_count = 0;

  assign tx_if.busy_in = model_busy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Transmitter model: optional delay before busy rises, then busy_len cycles busy.
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      model_busy  <= 1'b0;
      model_armed <= 1'b0;
      dly_cnt     <= 0;
      hold_cnt    <= 0;
    end else if (tx_if.byte_valid_out) begin
      model_armed <= 1'b1;
      dly_cnt     <= hi_delay;
    end else if (model_armed) begin
      if (dly_cnt > 0) dly_cnt <= dly_cnt - 1;
      else begin
        model_armed <= 1'b0;
        model_busy  <= 1'b1;
        hold_cnt    <= busy_len - 1;
      end
    end else if (model_busy) begin
      if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
      else model_busy <= 1'b0;
    end
  end

  always @(negedge clk_in) begin
    if (rst_n_in && tx_if.byte_valid_out) begin
      trig_count <= trig_count + 1;
      check_val("no_overlap", 32'({model_armed, model_busy}), 32'd0);
      check_val("exp_available", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_val("byte", 32'(tx_if.byte_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic push_packet(input logic [23:0] s0, input logic [23:0] s1,
                             input logic [7:0] seq, input int nbytes);
    logic [7:0] b [7];
    b[0] = 8'hA5;
    b[1] = seq;
    b[2] = s0[23:16];
    b[3] = s0[15:8];
    b[4] = s1[23:16];
    b[5] = s1[15:8];
    b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    for (int i = 0; i < nbytes; i++) exp_q.push_back(b[i]);
  endtask

  task automatic capture(input logic [23:0] s0, input logic [23:0] s1);
    @(posedge clk_in); #1;
    audio_in[0]    = s0;
    audio_in[1]    = s1;
    audio_valid_in = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    audio_valid_in = 1'b0;
  endtask

  task automatic wait_pkt_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_in); #1;
      if (exp_q.size() == 0 && !frame_active_out) break;
    end
    check_val({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_inactive"}, 32'(frame_active_out), 32'd0);
    $display("packet %s: seq_out=%0d overruns=%0d", tag, seq_out, overrun_count_out);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    int seen;
    logic [23:0] r0, r1;

    rst_n_in       = 1'b0;
    en_in          = 1'b0;
    audio_valid_in = 1'b0;
    audio_in       = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check_val("rst_byte",   32'(tx_if.byte_out),       32'd0);
    check_val("rst_valid",  32'(tx_if.byte_valid_out), 32'd0);
    check_val("rst_active", 32'(frame_active_out),     32'd0);
    check_val("rst_seq",    32'(seq_out),              32'd0);
    check_val("rst_ovr",    32'(overrun_count_out),    32'd0);
    rst_n_in = 1'b1;
    en_in    = 1'b1;

    // Basic packet and first-trigger latency.
    push_packet(24'h123456, 24'hABCDEF, 8'd0, 7);
    @(posedge clk_in); #1;
    audio_in[0] = 24'h123456;
    audio_in[1] = 24'hABCDEF;
    audio_valid_in = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in); #1;
      lat++;
      if (tx_if.byte_valid_out) break;
    end
    audio_valid_in = 1'b0;
    check_val("first_latency", 32'(lat - 1), 32'd2);
    check_val("active_in_pkt", 32'(frame_active_out), 32'd1);
    wait_pkt_done("basic");
    check_val("seq_after_basic", 32'(seq_out), 32'd1);
    check_val("ovr_after_basic", 32'(overrun_count_out), 32'd0);

    // Three captures: the first is sent, the second is dropped by the third.
    push_packet(24'h111111, 24'h222222, 8'd1, 7);
    capture(24'h111111, 24'h222222);
    capture(24'h333333, 24'h444444);
    capture(24'h555555, 24'h666666);
    check_val("ovr_count", 32'(overrun_count_out), 32'd1);
    push_packet(24'h555555, 24'h666666, 8'd2, 7);
    wait_pkt_done("overrun");
    check_val("ovr_after", 32'(overrun_count_out), 32'd1);
    check_val("seq_after_ovr", 32'(seq_out), 32'd3);

    // Disabled: frame stays pending until en_in returns.
    en_in = 1'b0;
    base = trig_count;
    capture(24'h0F1E2D, 24'h3C4B5A);
    repeat (20) @(posedge clk_in);
    #1;
    check_val("no_trig_disabled", 32'(trig_count - base), 32'd0);
    check_val("inactive_disabled", 32'(frame_active_out), 32'd0);
    push_packet(24'h0F1E2D, 24'h3C4B5A, 8'd3, 7);
    en_in = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in); #1;
      lat++;
      if (tx_if.byte_valid_out) break;
    end
    check_val("enable_latency", 32'(lat), 32'd2);
    wait_pkt_done("enable");

    // Transmitter slow to raise busy: no re-trigger while waiting.
    hi_delay = 10;
    base = trig_count;
    push_packet(24'hFEDCBA, 24'h987654, 8'd4, 7);
    capture(24'hFEDCBA, 24'h987654);
    wait_pkt_done("slow_busy");
    check_val("slow_trig_count", 32'(trig_count - base), 32'd7);
    hi_delay = 0;

    // 256 packets: sequence wraps through FF -> 00.
    busy_len = 1;
    for (int k = 0; k < 256; k++) begin
      r0 = 24'($urandom);
      r1 = 24'($urandom);
      push_packet(r0, r1, 8'(5 + k), 7);
      capture(r0, r1);
      wait_pkt_done($sformatf("wrap%0d", k));
    end
    check_val("seq_after_wrap", 32'(seq_out), 32'd5);
    busy_len = 3;

    // Reset while the fourth byte is being triggered.
    push_packet(24'hC0FFEE, 24'hBADA55, 8'd5, 3);
    @(posedge clk_in); #1;
    audio_in[0] = 24'hC0FFEE;
    audio_in[1] = 24'hBADA55;
    audio_valid_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_in); #1;
      if (i == 2) audio_valid_in = 1'b0;
      if (tx_if.byte_valid_out) begin
        seen++;
        if (seen == 4) break;
      end
    end
    audio_valid_in = 1'b0;
    check_val("reached_byte3", 32'(seen), 32'd4);
    rst_n_in = 1'b0;
    #1;
    check_val("rst_mid_valid",  32'(tx_if.byte_valid_out), 32'd0);
    check_val("rst_mid_active", 32'(frame_active_out),     32'd0);
    check_val("rst_mid_seq",    32'(seq_out),              32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    check_val("rst_mid_flushed", 32'(exp_q.size()), 32'd0);
    rst_n_in = 1'b1;
    push_packet(24'h765432, 24'h10FEDC, 8'd0, 7);
    capture(24'h765432, 24'h10FEDC);
    wait_pkt_done("after_reset");
    check_val("seq_after_reset", 32'(seq_out), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
